// File: rtl/flow_key_hash_pkg.sv
// rtl/flow_key_hash_pkg.sv - shared constants and helpers for the flow key hash block
package flow_key_hash_pkg;

    localparam int WINDOW_CYCLES = 160000000;
    localparam int HOLD_CYCLES   = 1040;
    localparam int TUPLE_WIDTH   = 104;
    localparam int PORT_WIDTH    = 3;
    localparam int CNT_WIDTH     = 28;
    localparam int DROP_WIDTH    = 32;

    localparam logic [PORT_WIDTH-1:0] IDLE_PORT     = 3'd6;
    localparam logic [PORT_WIDTH-1:0] MAX_PHYS_PORT = 3'd3;

    function automatic logic [DROP_WIDTH-1:0] sat_inc32(input logic [DROP_WIDTH-1:0] v);
        return (v == {DROP_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/flow_key_fifo.sv
// rtl/flow_key_fifo.sv - circular hold buffer for {port, hash} entries
module flow_key_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full buffer still succeeds when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/flow_key_hash.sv
// rtl/flow_key_hash.sv - hashes parsed flow keys to table addresses, holding them off during window clear
module flow_key_hash
    import flow_key_hash_pkg::*;
#(
    parameter int DEPTH_WIDTH   = 10,
    parameter int WINDOW_CYCLES = flow_key_hash_pkg::WINDOW_CYCLES,
    parameter int HOLD_CYCLES   = flow_key_hash_pkg::HOLD_CYCLES,
    parameter int FIFO_DEPTH    = 32
) (
    input  logic                   asclk,
    input  logic                   aresetn,
    input  logic                   key_valid,
    input  logic [TUPLE_WIDTH-1:0] key_tuple,
    input  logic [PORT_WIDTH-1:0]  key_port,
    output logic [CNT_WIDTH-1:0]   cnt_time,
    output logic [PORT_WIDTH-1:0]  proc_port,
    output logic [DEPTH_WIDTH-1:0] addr_hash,
    output logic [DROP_WIDTH-1:0]  drop_cnt
);

    localparam int EW     = PORT_WIDTH + DEPTH_WIDTH;
    localparam int NSLICE = (TUPLE_WIDTH + DEPTH_WIDTH - 1) / DEPTH_WIDTH;
    localparam logic [CNT_WIDTH-1:0] WIN = CNT_WIDTH'(WINDOW_CYCLES);

    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   hold_q, hold_d;
    logic [31:0]            hold_cnt_q, hold_cnt_d;
    logic                   wrap;
    logic [NSLICE*DEPTH_WIDTH-1:0] tuple_pad;
    logic [DEPTH_WIDTH-1:0] hash;
    logic                   a_valid_q;
    logic [EW-1:0]          a_entry_q;
    logic [PORT_WIDTH-1:0]  proc_port_q, proc_port_d;
    logic [DEPTH_WIDTH-1:0] addr_hash_q, addr_hash_d;
    logic [DROP_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   block, enq, deq, direct, drop;
    logic                   fifo_full, fifo_empty;
    logic [EW-1:0]          fifo_rdata;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign wrap       = (cnt_q == WIN);
    assign cnt_d      = wrap ? CNT_WIDTH'(1) : cnt_q + 1'b1;
    assign hold_d     = wrap || (hold_q && (hold_cnt_q != '0));
    assign hold_cnt_d = wrap ? 32'(HOLD_CYCLES - 1)
                      : (hold_q && (hold_cnt_q != '0)) ? hold_cnt_q - 1'b1 : hold_cnt_q;

    always_comb begin
        tuple_pad                  = '0;
        tuple_pad[TUPLE_WIDTH-1:0] = key_tuple;
        hash                       = '0;
        for (int i = 0; i < NSLICE; i++) begin
            hash = hash ^ tuple_pad[i*DEPTH_WIDTH +: DEPTH_WIDTH];
        end
    end

    // Gating on next-cycle hold keeps the output register idle for every hold cycle.
    assign block  = hold_d;
    assign deq    = !block && !fifo_empty;
    assign direct = a_valid_q && !block && fifo_empty;
    assign enq    = a_valid_q && (block || !fifo_empty);
    assign drop   = enq && fifo_full && !deq;

    always_comb begin
        proc_port_d = IDLE_PORT;
        addr_hash_d = '0;
        if (direct) begin
            {proc_port_d, addr_hash_d} = a_entry_q;
        end else if (deq) begin
            {proc_port_d, addr_hash_d} = fifo_rdata;
        end
        drop_cnt_d = drop ? sat_inc32(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge asclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            hold_cnt_q  <= '0;
            a_valid_q   <= 1'b0;
            a_entry_q   <= '0;
            proc_port_q <= IDLE_PORT;
            addr_hash_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            a_valid_q   <= key_valid && (key_port <= MAX_PHYS_PORT);
            a_entry_q   <= {key_port, hash};
            proc_port_q <= proc_port_d;
            addr_hash_q <= addr_hash_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    flow_key_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (asclk),
        .rst_ni      (rst_n),
        .push_i      (enq),
        .push_data_i (a_entry_q),
        .pop_i       (deq),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign cnt_time  = cnt_q;
    assign proc_port = proc_port_q;
    assign addr_hash = addr_hash_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_flow_key_hash.sv
// tb/tb_flow_key_hash.sv - scoreboard bench for flow_key_hash (deep and shallow hold buffer)
module tb_flow_key_hash;

    localparam int W = 100;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         key_valid;
    logic [103:0] key_tuple;
    logic [2:0]   key_port;

    logic [27:0]  cnt0, cnt1;
    logic [2:0]   pp0, pp1;
    logic [9:0]   ah0, ah1;
    logic [31:0]  dc0, dc1;

    logic [12:0]  q0[$];
    logic [12:0]  q1[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;
    int           exp_cnt  = 0;
    bit           model_on = 1'b0;
    bit           wrapped  = 1'b0;

    always #5 clk = ~clk;

    flow_key_hash #(.DEPTH_WIDTH(10), .WINDOW_CYCLES(W), .HOLD_CYCLES(H), .FIFO_DEPTH(32)) u0 (
        .asclk(clk), .aresetn(aresetn), .key_valid(key_valid), .key_tuple(key_tuple),
        .key_port(key_port), .cnt_time(cnt0), .proc_port(pp0), .addr_hash(ah0), .drop_cnt(dc0));

    flow_key_hash #(.DEPTH_WIDTH(10), .WINDOW_CYCLES(W), .HOLD_CYCLES(H), .FIFO_DEPTH(4)) u1 (
        .asclk(clk), .aresetn(aresetn), .key_valid(key_valid), .key_tuple(key_tuple),
        .key_port(key_port), .cnt_time(cnt1), .proc_port(pp1), .addr_hash(ah1), .drop_cnt(dc1));

    function automatic logic [9:0] hmodel(input logic [103:0] t);
        logic [109:0] p;
        logic [9:0]   h;
        p = {6'b0, t};
        for (int j = 0; j < 10; j++) begin
            h[j] = 1'b0;
            for (int k = 0; k < 11; k++) h[j] = h[j] ^ p[k*10 + j];
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [12:0] e;
        @(negedge clk);
        if (model_on) begin
            if (exp_cnt == W) begin
                exp_cnt = 1;
                wrapped = 1'b1;
            end else begin
                exp_cnt++;
            end
            chk("cnt_time_u0", 32'(cnt0), 32'(exp_cnt));
            chk("cnt_time_u1", 32'(cnt1), 32'(exp_cnt));
            if (wrapped && exp_cnt >= 1 && exp_cnt <= H) begin
                chk("hold_idle_u0", 32'(pp0), 32'd6);
                chk("hold_idle_u1", 32'(pp1), 32'd6);
            end
        end
        if (pp0 != 3'd6) begin
            if (q0.size() == 0) chk("u0_unexpected_emit", 32'(pp0), 32'd6);
            else begin
                e = q0.pop_front();
                chk("u0_emit", 32'({pp0, ah0}), 32'(e));
            end
        end
        if (pp1 != 3'd6) begin
            if (q1.size() == 0) chk("u1_unexpected_emit", 32'(pp1), 32'd6);
            else begin
                e = q1.pop_front();
                chk("u1_emit", 32'({pp1, ah1}), 32'(e));
            end
        end
    endtask

    task automatic send(input logic [103:0] t, input logic [2:0] p, input bit to1);
        key_valid = 1'b1;
        key_tuple = t;
        key_port  = p;
        if (p <= 3'd3) begin
            q0.push_back({p, hmodel(t)});
            if (to1) q1.push_back({p, hmodel(t)});
        end
        tick();
        key_valid = 1'b0;
    endtask

    task automatic align();
        bit ok;
        ok = 1'b0;
        model_on = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (cnt0 == 28'd1) ok = 1'b1;
        end
        chk("align_cnt_start", 32'(cnt0), 32'd1);
        exp_cnt  = 1;
        wrapped  = 1'b0;
        model_on = 1'b1;
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 3*W && exp_cnt != target; i++) tick();
        chk("wait_cnt_budget", 32'(exp_cnt), 32'(target));
    endtask

    function automatic logic [103:0] rkey();
        return {$urandom, $urandom, $urandom, 8'($urandom)};
    endfunction

    task automatic hold_burst(input int nkeys, input int n_u1);
        wait_cnt(W);
        tick();
        for (int k = 0; k < nkeys; k++) send(rkey(), 3'(k % 4), k < n_u1);
        wait_cnt(H);
        for (int k = 0; k < nkeys; k++) begin
            tick();
            chk("drain_u0_busy", 32'(pp0 != 3'd6), 32'd1);
            chk("drain_u1_busy", 32'(pp1 != 3'd6), 32'(k < n_u1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn   = 1'b0;
        key_valid = 1'b0;
        key_tuple = '0;
        key_port  = '0;
        repeat (3) tick();
        chk("reset_cnt_time", 32'(cnt0), 32'd0);
        chk("reset_proc_port", 32'(pp0), 32'd6);
        chk("reset_addr_hash", 32'(ah0), 32'd0);
        chk("reset_drop_u0", dc0, 32'd0);
        chk("reset_drop_u1", dc1, 32'd0);
        aresetn = 1'b1;
        align();

        repeat (3) tick();
        key_valid = 1'b1;
        key_tuple = 104'h11;
        key_port  = 3'd2;
        q0.push_back({3'd2, 10'h011});
        q1.push_back({3'd2, 10'h011});
        tick();
        key_valid = 1'b0;
        tick();
        chk("lat2_proc_port", 32'(pp0), 32'd2);
        chk("lat2_addr_hash", 32'(ah0), 32'h011);

        for (int i = 0; i < 8; i++) send(rkey(), 3'(i), 1'b1);
        for (int i = 0; i < 4; i++) send(rkey(), 3'($urandom_range(0, 3)), 1'b1);
        send(rkey(), 3'd5, 1'b1);
        repeat (5) tick();
        chk("direct_q0_drained", 32'(q0.size()), 32'd0);
        chk("direct_q1_drained", 32'(q1.size()), 32'd0);
        chk("no_drop_u0", dc0, 32'd0);
        chk("no_drop_u1", dc1, 32'd0);

        hold_burst(5, 4);
        chk("w1_q0_empty", 32'(q0.size()), 32'd0);
        chk("w1_q1_empty", 32'(q1.size()), 32'd0);
        chk("w1_drop_u0", dc0, 32'd0);
        chk("w1_drop_u1", dc1, 32'd1);

        hold_burst(6, 4);
        chk("w2_q0_empty", 32'(q0.size()), 32'd0);
        chk("w2_drop_u0", dc0, 32'd0);
        chk("w2_drop_u1", dc1, 32'd3);

        wait_cnt(W);
        tick();
        for (int k = 0; k < 6; k++) send(rkey(), 3'(k % 4), k < 4);
        wait_cnt(H + 2);
        chk("w3_partial_drain", 32'(q0.size()), 32'd4);
        aresetn  = 1'b0;
        model_on = 1'b0;
        q0.delete();
        q1.delete();
        tick();
        chk("midreset_port_u0", 32'(pp0), 32'd6);
        chk("midreset_port_u1", 32'(pp1), 32'd6);
        chk("midreset_cnt", 32'(cnt0), 32'd0);
        chk("midreset_drop_u1", dc1, 32'd0);
        aresetn = 1'b1;
        align();
        repeat (20) tick();
        chk("post_reset_drop_u0", dc0, 32'd0);
        chk("post_reset_drop_u1", dc1, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
